// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetches, buffers up to two
// returned words in a small FIFO, and hands them to decode with redirect flushing.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output logic                  dec_valid,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [DATA_WIDTH-1:0] dec_pc,
  output logic [DATA_WIDTH-1:0] dec_pc_plus4
);

  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0] instr_q [2];
  logic [DATA_WIDTH-1:0] instr_d [2];
  logic [DATA_WIDTH-1:0] fpc_q [2];
  logic [DATA_WIDTH-1:0] fpc_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;

  logic       pop;
  logic       wr;
  logic       has_entry;
  logic [2:0] occupancy;

  always_comb begin
    has_entry    = (count_q != 2'd0);
    dec_valid    = !rst && has_entry && !redirect;
    dec_instr    = (has_entry && !rst) ? instr_q[rd_ptr_q] : NOP;
    dec_pc       = (has_entry && !rst) ? fpc_q[rd_ptr_q] : '0;
    dec_pc_plus4 = dec_pc + FOUR;

    pop = dec_valid && dec_ready;
    wr  = inflight_q && !redirect;

    // pop implies count > 0, so this never underflows
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    imem_req  = !rst && (redirect || (occupancy < 3'd2));
    imem_addr = redirect ? redirect_pc : pc_q;
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    fpc_d      = fpc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = imem_req;

    if (imem_req) begin
      pc_d     = imem_addr + FOUR;
      req_pc_d = imem_addr;
    end

    // A redirect flushes the FIFO and drops the response arriving this cycle.
    if (redirect) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (wr) begin
        instr_d[wr_ptr_q] = imem_rdata;
        fpc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d          = !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      count_d = count_q + {1'b0, wr} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      fpc_q[0]   <= '0;
      fpc_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      instr_q    <= instr_d;
      fpc_q      <= fpc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction, PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory this cycle.
REQ-006 SHALL have port imem_addr  output  DATA_WIDTH  fetch byte address.
REQ-007 SHALL have port imem_rdata  input  DATA_WIDTH  instruction word, valid the cycle after a request.
REQ-008 SHALL have port redirect  input  1  taken branch/jump from a later stage.
REQ-009 SHALL have port redirect_pc  input  DATA_WIDTH  redirect target address.
REQ-010 SHALL have port dec_ready  input  1  decode (the immediate-generation stage) accepts an instruction.
REQ-011 SHALL have port dec_valid  output  1  dec_instr/dec_pc hold a valid instruction.
REQ-012 SHALL have port dec_instr  output  DATA_WIDTH  instruction word to decode.
REQ-013 SHALL have port dec_pc  output  DATA_WIDTH  address of dec_instr.
REQ-014 SHALL have port dec_pc_plus4  output  DATA_WIDTH  dec_pc + 4, modulo 2^DATA_WIDTH.

Function
REQ-015 SHALL hold a fetch PC register, a 2-entry FIFO of {instr, pc}, a count (0..2) and an inflight bit.
REQ-016 SHALL define pop = dec_valid && dec_ready.
REQ-017 SHALL set inflight to the value of imem_req at each rising edge.
REQ-018 SHALL assert imem_req when redirect=1, or when count + inflight - pop < 2; otherwise imem_req=0.
REQ-019 SHALL drive imem_addr = redirect_pc when redirect=1; otherwise imem_addr = PC.
REQ-020 SHALL, on an issued request, load PC with imem_addr + 4, wrapping modulo 2^DATA_WIDTH.
REQ-021 SHALL, when inflight=1 and redirect=0, write {imem_rdata, PC of that request} to the FIFO tail at the edge.
REQ-022 SHALL update count as count + write - pop; the REQ-018 rule guarantees no overflow.
REQ-023 SHALL drive dec_valid = (count > 0) && !redirect.
REQ-024 SHALL drive dec_instr/dec_pc from the FIFO head when count > 0.
REQ-025 SHALL drive dec_instr = 32'h00000013 (NOP) and dec_pc = 0 when count = 0.
REQ-026 SHALL, on redirect in cycle N, clear the FIFO at the edge and discard the response arriving in cycle N.
REQ-027 SHALL ignore dec_ready in a redirect cycle; redirect has priority over pop and write.
REQ-028 SHALL, after redirect in cycle N, present redirect_pc on dec_pc with dec_valid=1 in cycle N+2.
REQ-029 SHALL, with dec_ready held 1, deliver one instruction per cycle in steady state.
REQ-030 SHALL leave the FIFO unchanged while dec_ready=0; imem_req drops once count + inflight = 2.
REQ-031 SHALL update the FIFO correctly when write and pop coincide at count=2, keeping order.

Reset
REQ-032 SHALL, while rst=1, immediately force PC=RESET_PC, count=0, inflight=0, FIFO pointers=0.
REQ-033 SHALL, while rst=1, drive imem_req=0, dec_valid=0, dec_instr=NOP and dec_pc=0, without a clock edge.
REQ-034 SHALL, in the first cycle with rst=0, assert imem_req with imem_addr=RESET_PC.
REQ-035 SHALL assert dec_valid two cycles after that first request.
REQ-036 SHALL, when rst is asserted mid-stream, discard any in-flight response.

Verification
REQ-037 Release reset, dec_ready=1 -> imem_addr 0,4,8,... every cycle; dec_pc 0,4,8 from cycle 2, one per cycle; dec_pc_plus4 = dec_pc+4.
REQ-038 Release reset, dec_ready=0 -> two requests (0,4) then imem_req=0 and the head holds pc 0. Then set dec_ready=1 -> dec_pc 0,4,8 in order, none lost or duplicated.
REQ-039 Full FIFO with redirect_pc=0x100 pulsed in cycle N -> dec_valid=0 in cycles N and N+1, imem_addr=0x100 in N, dec_pc=0x100 in N+2, then 0x104.
REQ-040 Redirect in a cycle with inflight=1 and imem_rdata=0xDEADBEEF -> 0xDEADBEEF never appears on dec_instr.
REQ-041 redirect_pc=0xFFFFFFFC -> next imem_addr=0x00000000; dec_pc_plus4=0x00000000 for that instruction.
REQ-042 Assert rst asynchronously mid-stream between edges -> dec_valid and imem_req fall immediately. After release, fetch restarts at RESET_PC per REQ-034/035.
